// File: rtl/stk_ctx_lk_if.sv
// Command/response bundle for the shared-pool multi-context stack.
// The slave modport is the stack itself; master is the command issuer.
interface stk_ctx_lk_if #(
    parameter int ENGS_N  = 4,
    parameter int LINES_N = 16,
    parameter int DAT_W   = 128
);
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int CNT_W   = $clog2(LINES_N + 1);

    logic               i_cmd_vld;
    logic               o_cmd_rdy;
    logic [ENGID_W-1:0] i_cmd_engid;
    logic [1:0]         i_cmd_opcode;
    logic [DAT_W-1:0]   i_cmd_dat;
    logic               o_rsp_vld;
    logic [ENGID_W-1:0] o_rsp_engid;
    logic [1:0]         o_rsp_opcode;
    logic [DAT_W-1:0]   o_rsp_dat;
    logic               o_rsp_err;
    logic [ENGS_N-1:0]  o_empty;
    logic [CNT_W-1:0]   o_free_cnt;
    logic               o_busy;

    modport slave (
        input  i_cmd_vld, i_cmd_engid, i_cmd_opcode, i_cmd_dat,
        output o_cmd_rdy, o_rsp_vld, o_rsp_engid, o_rsp_opcode, o_rsp_dat,
        output o_rsp_err, o_empty, o_free_cnt, o_busy
    );

    modport master (
        output i_cmd_vld, i_cmd_engid, i_cmd_opcode, i_cmd_dat,
        input  o_cmd_rdy, o_rsp_vld, o_rsp_engid, o_rsp_opcode, o_rsp_dat,
        input  o_rsp_err, o_empty, o_free_cnt, o_busy
    );
endinterface

// File: rtl/stk_ctx_lk.sv
// Several LIFO contexts sharing one pool of lines; each context is a linked
// list threaded through prev[], unused lines are kept in a free-list FIFO.
module stk_ctx_lk #(
    parameter int ENGS_N  = 4,
    parameter int LINES_N = 16,
    parameter int DAT_W   = 128
) (
    input logic          clk,
    input logic          rst,
    stk_ctx_lk_if.slave  bus
);
    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;
    localparam int PTR_W   = $clog2(LINES_N);
    localparam int CNT_W   = $clog2(LINES_N + 1);

    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd3;

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_FLUSH = 2'd2} state_t;

    state_t             state_r, state_s;
    logic [DAT_W-1:0]   data_r   [LINES_N];
    logic [PTR_W-1:0]   prev_r   [LINES_N];
    logic [PTR_W-1:0]   fl_mem_r [LINES_N];
    logic [PTR_W-1:0]   head_r   [ENGS_N];
    logic [CNT_W-1:0]   cnt_r    [ENGS_N];
    logic [ENGS_N-1:0]  empty_r;
    logic [PTR_W-1:0]   fl_rd_r, fl_wr_r;
    logic [CNT_W-1:0]   fl_cnt_r;
    logic [ENGID_W-1:0] flush_eng_r, flush_eng_s, eng_s;
    logic [PTR_W-1:0]   head_cur_s, new_line_s;
    logic [CNT_W-1:0]   cnt_cur_s;
    logic               cmd_acc_s, init_wr_s, do_push_s, do_pop_s;
    logic               rsp_vld_s, rsp_err_s;
    logic [1:0]         rsp_op_s;
    logic [DAT_W-1:0]   rsp_dat_s;
    logic               rsp_vld_r, rsp_err_r;
    logic [1:0]         rsp_op_r;
    logic [ENGID_W-1:0] rsp_eng_r;
    logic [DAT_W-1:0]   rsp_dat_r;

    assign cmd_acc_s  = bus.i_cmd_vld && (state_r == ST_IDLE);
    assign init_wr_s  = (state_r == ST_INIT);
    assign eng_s      = (state_r == ST_FLUSH) ? flush_eng_r : bus.i_cmd_engid;
    assign head_cur_s = head_r[eng_s];
    assign cnt_cur_s  = cnt_r[eng_s];
    assign new_line_s = fl_mem_r[fl_rd_r];

    // Next-state decode and per-cycle pool operation select
    always_comb begin
        state_s     = state_r;
        flush_eng_s = flush_eng_r;
        do_push_s   = 1'b0;
        do_pop_s    = 1'b0;
        rsp_vld_s   = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_op_s    = 2'd0;
        rsp_dat_s   = '0;
        case (state_r)
            ST_INIT: begin
                if (fl_cnt_r == CNT_W'(LINES_N - 1)) state_s = ST_IDLE;
                else                                 state_s = ST_INIT;
            end
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    rsp_vld_s = 1'b1;
                    rsp_op_s  = bus.i_cmd_opcode;
                    case (bus.i_cmd_opcode)
                        OP_PUSH: begin
                            if (fl_cnt_r != '0) do_push_s = 1'b1;
                            else                rsp_err_s = 1'b1;
                        end
                        OP_POP: begin
                            if (cnt_cur_s != '0) begin
                                do_pop_s  = 1'b1;
                                rsp_dat_s = data_r[head_cur_s];
                            end else begin
                                rsp_err_s = 1'b1;
                            end
                        end
                        OP_INV: begin
                            // Non-empty flush answers during its last cycle, one step early
                            if (cnt_cur_s != '0) begin
                                state_s     = ST_FLUSH;
                                flush_eng_s = bus.i_cmd_engid;
                                rsp_vld_s   = (cnt_cur_s == CNT_W'(1));
                            end else begin
                                rsp_vld_s   = 1'b1;
                            end
                        end
                        default: rsp_err_s = 1'b0;
                    endcase
                end else begin
                    rsp_vld_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                do_pop_s  = (cnt_cur_s != '0);
                rsp_op_s  = OP_INV;
                rsp_vld_s = (cnt_cur_s == CNT_W'(2));
                if (cnt_cur_s <= CNT_W'(1)) state_s = ST_IDLE;
                else                        state_s = ST_FLUSH;
            end
            default: state_s = ST_INIT;
        endcase
    end

    // Control state, per-context bookkeeping, free-list pointers and response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            flush_eng_r <= '0;
            fl_rd_r     <= '0;
            fl_wr_r     <= '0;
            fl_cnt_r    <= '0;
            empty_r     <= '1;
            rsp_vld_r   <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_op_r    <= 2'd0;
            rsp_eng_r   <= '0;
            rsp_dat_r   <= '0;
            for (int i = 0; i < ENGS_N; i++) begin
                head_r[i] <= '0;
                cnt_r[i]  <= '0;
            end
        end else begin
            state_r     <= state_s;
            flush_eng_r <= flush_eng_s;
            rsp_vld_r   <= rsp_vld_s;
            rsp_err_r   <= rsp_vld_s & rsp_err_s;
            rsp_op_r    <= rsp_vld_s ? rsp_op_s : 2'd0;
            rsp_eng_r   <= rsp_vld_s ? eng_s : '0;
            rsp_dat_r   <= rsp_vld_s ? rsp_dat_s : '0;
            if (init_wr_s || do_pop_s) begin
                fl_wr_r  <= fl_wr_r + PTR_W'(1);
                fl_cnt_r <= fl_cnt_r + CNT_W'(1);
            end else if (do_push_s) begin
                fl_rd_r  <= fl_rd_r + PTR_W'(1);
                fl_cnt_r <= fl_cnt_r - CNT_W'(1);
            end
            if (do_push_s) begin
                head_r[eng_s]  <= new_line_s;
                cnt_r[eng_s]   <= cnt_cur_s + CNT_W'(1);
                empty_r[eng_s] <= 1'b0;
            end else if (do_pop_s) begin
                head_r[eng_s]  <= prev_r[head_cur_s];
                cnt_r[eng_s]   <= cnt_cur_s - CNT_W'(1);
                empty_r[eng_s] <= (cnt_cur_s == CNT_W'(1));
            end
        end
    end

    // Storage arrays carry no reset; INIT rebuilds the free list from scratch
    always_ff @(posedge clk) begin
        if (init_wr_s)     fl_mem_r[fl_wr_r] <= fl_wr_r;
        else if (do_pop_s) fl_mem_r[fl_wr_r] <= head_cur_s;
        if (do_push_s) begin
            data_r[new_line_s] <= bus.i_cmd_dat;
            prev_r[new_line_s] <= head_cur_s;
        end
    end

    assign bus.o_cmd_rdy    = (state_r == ST_IDLE);
    assign bus.o_busy       = (state_r == ST_INIT) || (state_r == ST_FLUSH);
    assign bus.o_empty      = empty_r;
    assign bus.o_free_cnt   = fl_cnt_r;
    assign bus.o_rsp_vld    = rsp_vld_r;
    assign bus.o_rsp_err    = rsp_err_r;
    assign bus.o_rsp_opcode = rsp_op_r;
    assign bus.o_rsp_engid  = rsp_eng_r;
    assign bus.o_rsp_dat    = rsp_dat_r;
endmodule

// File: tb/tb_stk_ctx_lk.sv
// Self-checking bench for stk_ctx_lk: directed scenarios plus a randomized
// run against a queue-per-context stack model.
module tb_stk_ctx_lk;
    localparam int ENGS_N  = 4;
    localparam int LINES_N = 16;
    localparam int DAT_W   = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stk_ctx_lk_if #(.ENGS_N(ENGS_N), .LINES_N(LINES_N), .DAT_W(DAT_W)) bus ();
    stk_ctx_lk #(.ENGS_N(ENGS_N), .LINES_N(LINES_N), .DAT_W(DAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [DAT_W-1:0] stk [ENGS_N][$];

    function automatic int model_free();
        int s = LINES_N;
        for (int i = 0; i < ENGS_N; i++) s -= stk[i].size();
        return s;
    endfunction

    function automatic logic [ENGS_N-1:0] model_empty();
        logic [ENGS_N-1:0] m;
        for (int i = 0; i < ENGS_N; i++) m[i] = (stk[i].size() == 0);
        return m;
    endfunction

    function automatic logic [DAT_W-1:0] rnd_dat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one command, hold it until ready, return one negedge after acceptance
    task automatic issue(input int e, input logic [1:0] op, input logic [DAT_W-1:0] d);
        int guard = 0;
        @(negedge clk);
        bus.i_cmd_vld    = 1'b1;
        bus.i_cmd_engid  = 2'(e);
        bus.i_cmd_opcode = op;
        bus.i_cmd_dat    = d;
        while (!bus.o_cmd_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.o_cmd_rdy) begin
            n_total++;
            $display("FAIL issue_timeout: rdy=%0b required=1", bus.o_cmd_rdy);
        end
        @(negedge clk);
        bus.i_cmd_vld = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (LINES_N) @(negedge clk);
        for (int i = 0; i < ENGS_N; i++) stk[i].delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({bus.o_cmd_rdy, bus.o_busy, bus.o_rsp_vld, bus.o_rsp_err, bus.o_free_cnt, bus.o_empty}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b1111}) begin
            $display("FAIL reset_state: rdy/busy/vld/err/free/empty=%b %b %b %b %0d %b required 0 1 0 0 0 1111",
                     bus.o_cmd_rdy, bus.o_busy, bus.o_rsp_vld, bus.o_rsp_err, bus.o_free_cnt, bus.o_empty);
        end else n_pass++;
        n_total++;
        if ({bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_dat} !== '0) begin
            $display("FAIL reset_rsp: op=%0d eng=%0d dat=%h required all zero",
                     bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_dat);
        end else n_pass++;
        repeat (LINES_N - 1) @(negedge clk);
        n_total++;
        if ({bus.o_cmd_rdy, bus.o_free_cnt} !== {1'b0, 5'd15}) begin
            $display("FAIL init_cycle15: rdy=%0b free=%0d required 0 15", bus.o_cmd_rdy, bus.o_free_cnt);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.o_cmd_rdy, bus.o_busy, bus.o_free_cnt, bus.o_empty} !== {1'b1, 1'b0, 5'd16, 4'b1111}) begin
            $display("FAIL init_done: rdy=%0b busy=%0b free=%0d empty=%b required 1 0 16 1111",
                     bus.o_cmd_rdy, bus.o_busy, bus.o_free_cnt, bus.o_empty);
        end else n_pass++;
        for (int i = 0; i < ENGS_N; i++) stk[i].delete();
    endtask

    task automatic test_push_pop();
        logic [DAT_W-1:0] va, vb;
        va = DAT_W'(128'hA);
        vb = DAT_W'(128'hB);
        issue(0, 2'd1, va);
        issue(0, 2'd1, vb);
        issue(0, 2'd2, '0);
        n_total++;
        if ({bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_dat} !== {1'b1, 1'b0, vb}) begin
            $display("FAIL pushpop_first: vld=%0b err=%0b dat=%h required 1 0 %h",
                     bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_dat, vb);
        end else n_pass++;
        issue(0, 2'd2, '0);
        n_total++;
        if ({bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_dat} !== {1'b1, 1'b0, va}) begin
            $display("FAIL pushpop_second: vld=%0b err=%0b dat=%h required 1 0 %h",
                     bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_dat, va);
        end else n_pass++;
        n_total++;
        if ({bus.o_empty[0], bus.o_free_cnt} !== {1'b1, 5'd16}) begin
            $display("FAIL pushpop_end: empty0=%0b free=%0d required 1 16", bus.o_empty[0], bus.o_free_cnt);
        end else n_pass++;
    endtask

    task automatic test_pop_empty();
        issue(2, 2'd2, '0);
        n_total++;
        if ({bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_dat, bus.o_free_cnt}
            !== {1'b1, 1'b1, 2'd2, 2'd2, {DAT_W{1'b0}}, 5'd16}) begin
            $display("FAIL pop_empty: vld=%0b err=%0b op=%0d eng=%0d dat=%h free=%0d required 1 1 2 2 0 16",
                     bus.o_rsp_vld, bus.o_rsp_err, bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_dat, bus.o_free_cnt);
        end else n_pass++;
    endtask

    task automatic test_exhaust();
        logic [DAT_W-1:0] d;
        logic             exp_err;
        for (int i = 0; i < LINES_N + 1; i++) begin
            d = rnd_dat();
            exp_err = (model_free() == 0);
            issue(i % 2, 2'd1, d);
            if (!exp_err) stk[i % 2].push_back(d);
            n_total++;
            if ({bus.o_rsp_vld, bus.o_rsp_err} !== {1'b1, exp_err}) begin
                $display("FAIL exhaust_push%0d: vld=%0b err=%0b required 1 %0b",
                         i, bus.o_rsp_vld, bus.o_rsp_err, exp_err);
            end else n_pass++;
            if (i == LINES_N - 1) begin
                n_total++;
                if (bus.o_free_cnt !== 5'd0) begin
                    $display("FAIL exhaust_free: free=%0d required 0", bus.o_free_cnt);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_inv();
        int low = 0, resp_k = 0;
        logic resp_err = 1'b1;
        for (int i = 0; i < 3; i++) issue(1, 2'd1, rnd_dat());
        issue(1, 2'd3, '0);
        for (int k = 1; k <= 4; k++) begin
            if (!bus.o_cmd_rdy) low++;
            if (bus.o_rsp_vld && resp_k == 0) begin
                resp_k   = k;
                resp_err = bus.o_rsp_err;
            end
            if (k < 4) @(negedge clk);
        end
        stk[1].delete();
        n_total++;
        if (low !== 3 || resp_k !== 3 || resp_err !== 1'b0) begin
            $display("FAIL inv_timing: rdy_low=%0d rsp_at=%0d err=%0b required 3 3 0", low, resp_k, resp_err);
        end else n_pass++;
        n_total++;
        if ({bus.o_empty[1], bus.o_free_cnt} !== {1'b1, 5'd16}) begin
            $display("FAIL inv_end: empty1=%0b free=%0d required 1 16", bus.o_empty[1], bus.o_free_cnt);
        end else n_pass++;
    endtask

    task automatic test_rst_flush();
        logic seen = 1'b0;
        for (int i = 0; i < 10; i++) issue(0, 2'd1, rnd_dat());
        issue(0, 2'd3, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ENGS_N; i++) stk[i].delete();
        if (bus.o_rsp_vld) seen = 1'b1;
        for (int k = 0; k < LINES_N; k++) begin
            @(negedge clk);
            if (bus.o_rsp_vld) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) begin
            $display("FAIL rstflush_norsp: seen=%0b required 0", seen);
        end else n_pass++;
        n_total++;
        if ({bus.o_cmd_rdy, bus.o_free_cnt, bus.o_empty} !== {1'b1, 5'd16, 4'b1111}) begin
            $display("FAIL rstflush_init: rdy=%0b free=%0d empty=%b required 1 16 1111",
                     bus.o_cmd_rdy, bus.o_free_cnt, bus.o_empty);
        end else n_pass++;
    endtask

    task automatic test_random();
        int               e, sel, lat, exp_lat, n;
        logic [1:0]       op;
        logic             exp_err;
        logic [DAT_W-1:0] d, exp_dat;
        for (int t = 0; t < 200; t++) begin
            e   = $urandom_range(0, ENGS_N - 1);
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 2'd0 : (sel <= 4) ? 2'd1 : (sel <= 8) ? 2'd2 : 2'd3;
            d   = rnd_dat();
            exp_err = 1'b0;
            exp_dat = '0;
            exp_lat = 1;
            n = stk[e].size();
            case (op)
                2'd1: if (model_free() > 0) stk[e].push_back(d); else exp_err = 1'b1;
                2'd2: if (n > 0) exp_dat = stk[e].pop_back(); else exp_err = 1'b1;
                2'd3: begin
                    if (n > 0) exp_lat = n;
                    stk[e].delete();
                end
                default: exp_err = 1'b0;
            endcase
            issue(e, op, d);
            lat = 1;
            while (!bus.o_rsp_vld && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            n_total++;
            if ({bus.o_rsp_vld, bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_err} !== {1'b1, op, 2'(e), exp_err}
                || lat != exp_lat) begin
                $display("FAIL rand%0d_rsp: vld=%0b op=%0d eng=%0d err=%0b lat=%0d required 1 %0d %0d %0b %0d",
                         t, bus.o_rsp_vld, bus.o_rsp_opcode, bus.o_rsp_engid, bus.o_rsp_err, lat,
                         op, e, exp_err, exp_lat);
            end else n_pass++;
            n_total++;
            if (bus.o_rsp_dat !== exp_dat) begin
                $display("FAIL rand%0d_dat: dat=%h required %h", t, bus.o_rsp_dat, exp_dat);
            end else n_pass++;
            if (op == 2'd3 && n > 0) @(negedge clk);
            n_total++;
            if ({bus.o_free_cnt, bus.o_empty} !== {5'(model_free()), model_empty()}) begin
                $display("FAIL rand%0d_state: free=%0d empty=%b required %0d %b",
                         t, bus.o_free_cnt, bus.o_empty, model_free(), model_empty());
            end else n_pass++;
        end
    endtask

    initial begin
        bus.i_cmd_vld    = 1'b0;
        bus.i_cmd_engid  = 2'd0;
        bus.i_cmd_opcode = 2'd0;
        bus.i_cmd_dat    = '0;
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_exhaust();
        do_reset();
        test_inv();
        test_rst_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stk_ctx_lk.md
STK_CTX_LK -- requirements
Module: stk_ctx_lk

Parameters
REQ-001 SHALL have parameter ENGS_N, default 4: number of independent stack contexts (engines), >=1.
REQ-002 SHALL have parameter LINES_N, default 16: shared entry pool depth, power of two, >=2.
REQ-003 SHALL have parameter DAT_W, default 128: data word width.
REQ-004 SHALL use derived widths ENGID_W=max(1,clog2(ENGS_N)), PTR_W=clog2(LINES_N), CNT_W=clog2(LINES_N+1).

Interface
REQ-005 SHALL have `clk`, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have `rst`, input, 1: synchronous, active-high reset.
REQ-007 SHALL have `i_cmd_vld`, input, 1: command valid.
REQ-008 SHALL have `o_cmd_rdy`, output, 1: command accepted when vld&rdy.
REQ-009 SHALL have `i_cmd_engid`, input, ENGID_W: target context.
REQ-010 SHALL have `i_cmd_opcode`, input, 2: 0=NOP, 1=PUSH, 2=POP, 3=INV (flush context).
REQ-011 SHALL have `i_cmd_dat`, input, DAT_W: PUSH data.
REQ-012 SHALL have `o_rsp_vld`, output, 1: single-cycle response strobe; no backpressure.
REQ-013 SHALL have `o_rsp_engid`, output, ENGID_W; `o_rsp_opcode`, output, 2; `o_rsp_dat`, output, DAT_W: POP data, otherwise 0.
REQ-014 SHALL have `o_rsp_err`, output, 1: PUSH with pool exhausted, or POP on an empty context.
REQ-015 SHALL have `o_empty`, output, ENGS_N: per-context empty flags.
REQ-016 SHALL have `o_free_cnt`, output, CNT_W: number of free pool lines.
REQ-017 SHALL have `o_busy`, output, 1: high in INIT or FLUSH state.

Function
REQ-018 SHALL hold internal state as follows:
- data array [LINES_N][DAT_W];
- prev array [LINES_N][PTR_W];
- head[ENGS_N] and cnt[ENGS_N] registers;
- free-list FIFO of PTR_W entries, depth LINES_N, with its own rd/wr pointers and count.
REQ-019 SHALL implement FSM states INIT, IDLE and FLUSH; o_cmd_rdy=1 only in IDLE.
REQ-020 INIT SHALL write pointer value k into the free list on cycle k, for k=0..LINES_N-1, then go to IDLE; INIT lasts LINES_N cycles.
REQ-021 Accepted NOP SHALL produce a response with err=0 and dat=0.
REQ-022 Accepted PUSH with free count >0 SHALL:
- pop pointer p from the free list;
- write data[p]=i_cmd_dat and prev[p]=head[e];
- set head[e]=p and increment cnt[e].
REQ-023 Accepted PUSH with free count ==0 SHALL change no state and respond with err=1.
REQ-024 Accepted POP with cnt[e]>0 SHALL:
- respond dat=data[head[e]];
- set head[e]=prev[head[e]];
- return the old head to the free list;
- decrement cnt[e].
REQ-025 Accepted POP with cnt[e]==0 SHALL change no state and respond with err=1, dat=0.
REQ-026 Accepted INV with cnt[e]==0 SHALL respond immediately with err=0.
REQ-027 Accepted INV with cnt[e]>0 SHALL enter FLUSH.
REQ-028 Each FLUSH cycle SHALL return head[e] to the free list, set head[e]=prev[head[e]] and decrement cnt[e].
REQ-029 On the cycle cnt[e] reaches 0, FLUSH SHALL respond (opcode=INV, err=0) and return to IDLE.
REQ-030 Response latency SHALL be exactly 1 cycle after acceptance for NOP, PUSH, POP and zero-count INV; all response outputs SHALL be registered.
REQ-031 For INV with cnt[e]=N>0, the response SHALL occur N cycles after acceptance.
REQ-032 o_empty[e] SHALL equal (cnt[e]==0), registered and consistent with state in the same cycle.
REQ-033 Free-list pointers SHALL wrap modulo LINES_N; simultaneous free-list push and pop cannot occur (at most one operation per cycle).
REQ-034 The sum of cnt[] plus o_free_cnt SHALL equal LINES_N whenever in IDLE.
REQ-035 A command with vld=1 and rdy=0 SHALL NOT be consumed; upstream holds it.

Reset
REQ-036 rst SHALL drive the following values next cycle:
- FSM=INIT;
- o_cmd_rdy=0, o_busy=1;
- o_rsp_vld=0, o_rsp_err=0, o_rsp_dat=0, o_rsp_engid=0, o_rsp_opcode=0;
- all cnt=0, all head=0;
- o_empty=all ones;
- free-list pointers=0, o_free_cnt=0.
REQ-037 rst asserted mid-FLUSH or mid-INIT SHALL abort the operation, with no response, and restart INIT.
REQ-038 Data and prev arrays SHALL NOT require reset.

Verification
REQ-039 Reset, then wait: after exactly LINES_N=16 cycles o_cmd_rdy=1, o_free_cnt=16, o_empty=4'b1111.
REQ-040 PUSH e0 0xA, PUSH e0 0xB, POP e0, POP e0 -> responses:
- dat 0xB, then 0xA;
- err=0;
- o_empty[0]=1 and o_free_cnt=16 at end.
REQ-041 POP e2 while empty -> err=1, dat=0, o_free_cnt unchanged.
REQ-042 17 PUSHes spread over e0/e1 -> first 16 give err=0 and o_free_cnt=0; 17th gives err=1.
REQ-043 PUSH 3 to e1, then INV e1 -> o_cmd_rdy low for 3 cycles, response 3 cycles after acceptance, o_empty[1]=1, o_free_cnt=16.
REQ-044 Assert rst during FLUSH -> no INV response, INIT rerun, o_free_cnt=16 after 16 cycles.
